// File: rtl/led_state_arbiter.sv
// led_state_arbiter: shares the 4-bit board LED state between three requesters
// (software status, navigation FSM, fault monitor) with fixed priority
// flt > nav > sw, a minimum display hold time and a sticky fault display.
// Hold and blink times are counted in ticks from a local prescaler.
//
// Optional feature: define LED_BLINK_EN to blink the fault pattern in FAULT
// (pattern / 4'b0000, BLINK_TICKS ticks per half-period, starting with the
// pattern). Without it the fault pattern is shown steady and no blink counter
// is built.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   sw_req/sw_pattern       software request (held until sw_ack) and pattern
//   sw_ack                  one-cycle accept pulse
//   nav_req/nav_pattern     navigation request and pattern
//   nav_ack                 one-cycle accept pulse
//   flt_req/flt_pattern     fault request and pattern
//   flt_ack                 one-cycle accept pulse
//   flt_clear               one-cycle fault release (ignored outside FAULT)
//   out_state               pattern driven to the LED stage
//   owner                   0 none, 1 sw, 2 nav, 3 flt
//   busy                    high in HOLD or FAULT
module led_state_arbiter #(
  parameter int unsigned TICK_DIV    = 1000000,
  parameter int unsigned HOLD_TICKS  = 50,
  parameter int unsigned BLINK_TICKS = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_req,
  input  logic [3:0] sw_pattern,
  output logic       sw_ack,
  input  logic       nav_req,
  input  logic [3:0] nav_pattern,
  output logic       nav_ack,
  input  logic       flt_req,
  input  logic [3:0] flt_pattern,
  output logic       flt_ack,
  input  logic       flt_clear,
  output logic [3:0] out_state,
  output logic [1:0] owner,
  output logic       busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_SW   = 2'd1;
  localparam logic [1:0] OWN_NAV  = 2'd2;
  localparam logic [1:0] OWN_FLT  = 2'd3;

  localparam int unsigned TW = $clog2(TICK_DIV + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam int unsigned HW = (HOLD_TICKS == 0) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);
  localparam bit HOLD_EN = (HOLD_TICKS != 0);

  logic [TW-1:0] tick_cnt_q;
  logic          tick_c;
  logic [1:0]    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    pat_q, pat_d;
  logic [3:0]    out_q, out_d;
  logic [1:0]    owner_q, owner_d;
  logic          busy_q, busy_d;
  logic          sw_ack_q, sw_ack_d;
  logic          nav_ack_q, nav_ack_d;
  logic          flt_ack_q, flt_ack_d;
  logic          sw_go, nav_go, flt_go;
  logic          lo_go;
  logic [3:0]    lo_pat;
  logic [1:0]    lo_own;

`ifdef LED_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_TICKS + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic          flt_entry;
`endif

  // Free-running prescaler; tick marks the cycle in which the count wraps.
  assign tick_c = (tick_cnt_q == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick_c ? '0 : tick_cnt_q + TW'(1);
  end

  // Arbitration and next-state logic.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    pat_d     = pat_q;
    owner_d   = owner_q;
    sw_ack_d  = 1'b0;
    nav_ack_d = 1'b0;
    flt_ack_d = 1'b0;
    lo_go     = 1'b0;
    lo_pat    = pat_q;
    lo_own    = owner_q;

    // A request whose ack is already out has been served; do not serve it twice.
    sw_go  = sw_req  & ~sw_ack_q;
    nav_go = nav_req & ~nav_ack_q;
    flt_go = flt_req & ~flt_ack_q;

    // sw/nav candidate: anyone in IDLE, only the current owner during HOLD.
    if (state_q == S_IDLE) begin
      if (nav_go) begin
        lo_go = 1'b1; lo_pat = nav_pattern; lo_own = OWN_NAV;
      end else if (sw_go) begin
        lo_go = 1'b1; lo_pat = sw_pattern;  lo_own = OWN_SW;
      end
    end else if (state_q == S_HOLD) begin
      if (owner_q == OWN_NAV && nav_go) begin
        lo_go = 1'b1; lo_pat = nav_pattern; lo_own = OWN_NAV;
      end else if (owner_q == OWN_SW && sw_go) begin
        lo_go = 1'b1; lo_pat = sw_pattern;  lo_own = OWN_SW;
      end
    end

    case (state_q)
      S_IDLE, S_HOLD: begin
        if (flt_go) begin
          state_d   = S_FAULT;
          pat_d     = flt_pattern;
          owner_d   = OWN_FLT;
          flt_ack_d = 1'b1;
          hold_d    = '0;
        end else if (lo_go) begin
          pat_d     = lo_pat;
          owner_d   = lo_own;
          sw_ack_d  = (lo_own == OWN_SW);
          nav_ack_d = (lo_own == OWN_NAV);
          hold_d    = HOLD_LOAD;
          state_d   = HOLD_EN ? S_HOLD : S_IDLE;
        end else if (state_q == S_HOLD && tick_c) begin
          if (hold_q <= HW'(1)) begin
            hold_d  = '0;
            state_d = S_IDLE;
          end else begin
            hold_d  = hold_q - HW'(1);
          end
        end
      end
      S_FAULT: begin
        // A new fault request outranks a simultaneous clear.
        if (flt_go) begin
          pat_d     = flt_pattern;
          flt_ack_d = 1'b1;
        end else if (flt_clear) begin
          state_d = S_IDLE;
          pat_d   = 4'h0;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        pat_d   = 4'h0;
        owner_d = OWN_NONE;
        hold_d  = '0;
      end
    endcase

    out_d  = pat_d;
    busy_d = (state_d != S_IDLE);

`ifdef LED_BLINK_EN
    // Half-period counter restarts with the pattern shown on every FAULT entry.
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    flt_entry   = flt_go && (state_q != S_FAULT);
    if (flt_entry) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (state_q == S_FAULT && tick_c) begin
      if (blink_cnt_q >= BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
    if (state_d == S_FAULT && !blink_on_d) out_d = 4'h0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      pat_q     <= 4'h0;
      out_q     <= 4'h0;
      owner_q   <= OWN_NONE;
      busy_q    <= 1'b0;
      sw_ack_q  <= 1'b0;
      nav_ack_q <= 1'b0;
      flt_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      pat_q     <= pat_d;
      out_q     <= out_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      sw_ack_q  <= sw_ack_d;
      nav_ack_q <= nav_ack_d;
      flt_ack_q <= flt_ack_d;
    end
  end

`ifdef LED_BLINK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end
`endif

  assign sw_ack    = sw_ack_q;
  assign nav_ack   = nav_ack_q;
  assign flt_ack   = flt_ack_q;
  assign out_state = out_q;
  assign owner     = owner_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_led_state_arbiter.sv
// Bench for led_state_arbiter with TICK_DIV=4, HOLD_TICKS=3, BLINK_TICKS=2.
// Every ack pulse is matched against a queue of expected acceptances.
module tb_led_state_arbiter;

  localparam int unsigned TD = 4;
  localparam int unsigned HT = 3;
  localparam int unsigned BT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_req = 1'b0, nav_req = 1'b0, flt_req = 1'b0, flt_clear = 1'b0;
  logic [3:0] sw_pattern = 4'h0, nav_pattern = 4'h0, flt_pattern = 4'h0;
  logic       sw_ack, nav_ack, flt_ack, busy;
  logic [3:0] out_state;
  logic [1:0] owner;

  led_state_arbiter #(.TICK_DIV(TD), .HOLD_TICKS(HT), .BLINK_TICKS(BT)) dut (
    .clk(clk), .rst_n(rst_n),
    .sw_req(sw_req), .sw_pattern(sw_pattern), .sw_ack(sw_ack),
    .nav_req(nav_req), .nav_pattern(nav_pattern), .nav_ack(nav_ack),
    .flt_req(flt_req), .flt_pattern(flt_pattern), .flt_ack(flt_ack),
    .flt_clear(flt_clear), .out_state(out_state), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;    // 1 sw, 2 nav, 3 flt
    logic [3:0] pat;
    logic [1:0] own;
  } exp_t;

  typedef struct {
    logic       s, n, f, c;
    logic [3:0] sp, np, fp;
    logic [2:0] exp_ack;   // {sw,nav,flt}
    logic [3:0] exp_out;
    logic [1:0] exp_own;
    logic       exp_busy;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   mon_id;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every ack must match the oldest expected acceptance.
  always @(negedge clk) begin
    if (rst_n && (sw_ack || nav_ack || flt_ack)) begin
      check("ack_onehot", $countones({sw_ack, nav_ack, flt_ack}), 1);
      mon_id = flt_ack ? 3 : (nav_ack ? 2 : 1);
      if (sbq.size() == 0) begin
        check("unexpected_ack_id", mon_id, 0);
      end else begin
        mon_e = sbq.pop_front();
        check("ack_id", mon_id, mon_e.id);
        check("ack_out_state", int'(out_state), int'(mon_e.pat));
        check("ack_owner", int'(owner), int'(mon_e.own));
      end
    end
  end

  function automatic logic req_of(input int id);
    case (id)
      1:       return sw_req;
      2:       return nav_req;
      default: return flt_req;
    endcase
  endfunction

  // One cycle: move to the next negedge; requesters drop req once acked.
  task automatic step();
    @(negedge clk);
    if (sw_ack)  sw_req  = 1'b0;
    if (nav_ack) nav_req = 1'b0;
    if (flt_ack) flt_req = 1'b0;
  endtask

  task automatic wait_drop(input int id, input int maxc, output int lat);
    lat = 0;
    while (req_of(id) && lat < maxc) begin
      step();
      lat++;
    end
    if (req_of(id)) begin
      check("ack_timeout_id", id, 0);
      case (id)
        1:       sw_req  = 1'b0;
        2:       nav_req = 1'b0;
        default: flt_req = 1'b0;
      endcase
    end
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    sw_req = 1'b0; nav_req = 1'b0; flt_req = 1'b0; flt_clear = 1'b0;
    sbq.delete();
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic push(input int id, input logic [3:0] pat, input logic [1:0] own);
    exp_t e;
    e.id = id; e.pat = pat; e.own = own;
    sbq.push_back(e);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    int   lat;
    int   bad;
    int   ntog;
    int   last_t;
    logic [3:0] prev;

    // Single-cycle arbitration from IDLE, each after a fresh reset.
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 4'h0, 4'h0, 3'b100, 4'hA, 2'd1, 1'b1};
    vt[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h5, 4'h0, 3'b010, 4'h5, 2'd2, 1'b1};
    vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'hF, 3'b001, 4'hF, 2'd3, 1'b1};
    vt[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'hC, 4'h6, 4'h0, 3'b010, 4'h6, 2'd2, 1'b1};
    vt[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'hC, 4'h0, 4'h8, 3'b001, 4'h8, 2'd3, 1'b1};
    vt[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h1, 4'h2, 4'hE, 3'b001, 4'hE, 2'd3, 1'b1};
    vt[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 3'b000, 4'h0, 2'd0, 1'b0};

    do_reset();
    check("reset_out_state", int'(out_state), 0);
    check("reset_owner", int'(owner), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_acks", int'({sw_ack, nav_ack, flt_ack}), 0);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      sw_req = vt[i].s; nav_req = vt[i].n; flt_req = vt[i].f; flt_clear = vt[i].c;
      sw_pattern = vt[i].sp; nav_pattern = vt[i].np; flt_pattern = vt[i].fp;
      if (vt[i].exp_ack != 3'b000)
        push(vt[i].exp_ack[0] ? 3 : (vt[i].exp_ack[1] ? 2 : 1), vt[i].exp_out, vt[i].exp_own);
      step();
      flt_clear = 1'b0;
      check("vec_acks", int'({sw_ack, nav_ack, flt_ack}), int'(vt[i].exp_ack));
      check("vec_out_state", int'(out_state), int'(vt[i].exp_out));
      check("vec_owner", int'(owner), int'(vt[i].exp_own));
      check("vec_busy", int'(busy), int'(vt[i].exp_busy));
    end

    // sw hold, same-owner reload, nav waits for the hold, fault preempts nav.
    do_reset();
    push(1, 4'hA, 2'd1);
    sw_pattern = 4'hA; sw_req = 1'b1;
    wait_drop(1, 4, lat);
    check("sw_latency", lat, 1);
    check("sw_busy", int'(busy), 1);
    step(); step();
    push(1, 4'hB, 2'd1);
    push(2, 4'h5, 2'd2);
    sw_pattern = 4'hB; sw_req = 1'b1;
    nav_pattern = 4'h5; nav_req = 1'b1;
    wait_drop(1, 4, lat);
    check("sw_reload_latency", lat, 1);
    wait_drop(2, 20, lat);
    check("nav_after_hold_in_window", int'(lat >= 10 && lat <= 13), 1);
    push(3, 4'hF, 2'd3);
    flt_pattern = 4'hF; flt_req = 1'b1;
    nav_pattern = 4'h7; nav_req = 1'b1;
    wait_drop(3, 4, lat);
    check("flt_preempt_latency", lat, 1);
    for (int k = 0; k < 10; k++) step();
    check("nav_stalled_in_fault", int'(nav_req), 1);
    check("fault_busy", int'(busy), 1);
    check("fault_owner", int'(owner), 3);
    check("fault_out_steady_check", int'(owner == 2'd3), 1);
    push(2, 4'h7, 2'd2);
    flt_clear = 1'b1;
    step();
    flt_clear = 1'b0;
    check("clear_out_state", int'(out_state), 0);
    check("clear_owner", int'(owner), 0);
    check("clear_busy", int'(busy), 0);
    wait_drop(2, 4, lat);
    check("nav_after_clear_latency", lat, 1);
    lat = 0;
    while (busy && lat < 20) begin step(); lat++; end
    check("nav_hold_expired", int'(busy), 0);
    check("idle_retains_out_state", int'(out_state), 7);
    check("idle_retains_owner", int'(owner), 2);

    // Simultaneous requests, stall in FAULT, withdrawal, clear+req together.
    do_reset();
    push(3, 4'h4, 2'd3);
    sw_pattern = 4'h1; nav_pattern = 4'h2; flt_pattern = 4'h4;
    sw_req = 1'b1; nav_req = 1'b1; flt_req = 1'b1;
    wait_drop(3, 4, lat);
    for (int k = 0; k < 8; k++) step();
    check("sw_nav_pending_in_fault", int'({sw_req, nav_req}), 3);
    sw_req = 1'b0;
    push(3, 4'h3, 2'd3);
    flt_pattern = 4'h3; flt_req = 1'b1; flt_clear = 1'b1;
    step();
    flt_clear = 1'b0;
    check("req_beats_clear_busy", int'(busy), 1);
    check("req_beats_clear_owner", int'(owner), 3);
    for (int k = 0; k < 5; k++) step();
    check("still_fault_busy", int'(busy), 1);
    check("still_fault_owner", int'(owner), 3);
    push(2, 4'h2, 2'd2);
    flt_clear = 1'b1;
    step();
    flt_clear = 1'b0;
    wait_drop(2, 4, lat);
    check("nav_pending_latency", lat, 1);
    for (int k = 0; k < 20; k++) step();

    // Fault display: blinking or steady, then asynchronous reset mid-display.
    do_reset();
    push(3, 4'h9, 2'd3);
    flt_pattern = 4'h9; flt_req = 1'b1;
    wait_drop(3, 4, lat);
`ifdef LED_BLINK_EN
    prev = out_state;
    check("blink_first_phase", int'(prev), 9);
    ntog = 0;
    last_t = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (out_state != prev) begin
        ntog++;
        check("blink_value", int'(out_state), (prev == 4'h9) ? 0 : 9);
        if (last_t >= 0) check("blink_period", k - last_t, 8);
        last_t = k;
        prev = out_state;
      end
    end
    check("blink_toggled", int'(ntog >= 4), 1);
`else
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (out_state != 4'h9) bad++;
    end
    check("steady_fault_bad_cycles", bad, 0);
`endif
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out_state", int'(out_state), 0);
    check("async_reset_owner", int'(owner), 0);
    check("async_reset_busy", int'(busy), 0);
    flt_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    check("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
